hex_display_scan: RTL and testbench

- Time-multiplexed driver for a bank of common-anode 7-segment digits; the parametrised successor of the team's single-digit hex decoder.
- Latches a packed multi-digit hex value on a load strobe and scans the digits round-robin at a programmable refresh rate.
- Drives active-low segments, decimal point and anodes, with optional anti-ghost blanking between digits.
- Sits between board-level display pins and any core that produces hex status words.

---
 rtl/hex_display_scan.sv | 125 ++++++++++++
 tb/tb_hex_display_scan.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Multiplexed common-anode hex display driver with registered, active-low pins.
// Optional leading-zero blanking is enabled by defining HEX_DISPLAY_LZB_EN.
module hex_display_scan #(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   x,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     en,
  output logic [6:0]             a_to_g,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [4*NDIGITS-1:0] x_q, x_d;
  logic [NDIGITS-1:0]   dpm_q, dpm_d, en_q, en_d;
  logic [PW-1:0]        p_q, p_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NDIGITS-1:0]   an_q, an_d;

  logic [3:0]           nib;
  logic                 dsel, esel, lzsel, dark, zacc;
  logic [NDIGITS-1:0]   lz_v, sel_an;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    x_d   = load ? x     : x_q;
    dpm_d = load ? dp_in : dpm_q;
    en_d  = load ? en    : en_q;

    p_d   = p_q + PW'(1);
    idx_d = idx_q;
    if (p_q == PW'(REFRESH_DIV - 1)) begin
      p_d   = '0;
      idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    // Scan from the top nibble down: digit k is a leading zero if it and all above are 0.
    lz_v = '0;
    zacc = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zacc    = zacc & (x_q[4*k +: 4] == 4'h0);
      lz_v[k] = (k > 0) && zacc;
    end

    nib    = 4'h0;
    dsel   = 1'b0;
    esel   = 1'b0;
    lzsel  = 1'b0;
    sel_an = '1;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib       = x_q[4*k +: 4];
        dsel      = dpm_q[k];
        esel      = en_q[k];
        lzsel     = lz_v[k];
        sel_an[k] = 1'b0;
      end
    end

`ifdef HEX_DISPLAY_LZB_EN
    dark = (int'(p_q) < BLANK_CYC) || !esel || lzsel;
`else
    dark = (int'(p_q) < BLANK_CYC) || !esel;
`endif

    an_d  = dark ? '1       : sel_an;
    seg_d = dark ? 7'h7F    : decode(nib);
    dp_d  = dark ? 1'b1     : ~dsel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      dpm_q <= '0;
      en_q  <= '0;
      p_q   <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      x_q   <= x_d;
      dpm_q <= dpm_d;
      en_q  <= en_d;
      p_q   <= p_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign a_to_g = seg_q;
  assign dp     = dp_q;
  assign an     = an_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench: two instances (no blanking / one blank cycle) share stimulus
// and are checked every cycle against a bench-side scan-position and decode model.
module tb_hex_display_scan;
  logic        clk = 1'b0;
  logic        rst_n, load;
  logic [15:0] x;
  logic [3:0]  dp_in, en;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] mx;
  logic [3:0]  mdp, men;
  logic [6:0]  dec [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  hex_display_scan #(.NDIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(0)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load), .x(x), .dp_in(dp_in), .en(en),
    .a_to_g(seg0), .dp(dp0), .an(an0));
  hex_display_scan #(.NDIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load), .x(x), .dp_in(dp_in), .en(en),
    .a_to_g(seg1), .dp(dp1), .an(an1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] o, input logic [6:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pins after edge n reflect the scan state of cycle n-1 since reset release.
  task automatic check_pins(input string tag);
    int c, idx, p;
    logic [15:0] sh;
    logic lz, dark;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    c   = cyc - 1;
    idx = (c / 4) % 4;
    p   = c % 4;
    sh  = mx >> (4 * idx);
`ifdef HEX_DISPLAY_LZB_EN
    lz = (idx > 0) && (sh == 16'h0);
`else
    lz = 1'b0;
`endif
    for (int b = 0; b < 2; b++) begin
      dark  = (p < b) || !men[idx] || lz;
      e_an  = dark ? 4'hF : ~(4'b0001 << idx);
      e_seg = dark ? 7'h7F : dec[sh[3:0]];
      e_dp  = dark ? 1'b1 : ~mdp[idx];
      if (b == 0) begin
        chk({tag, ".an0"},  {3'b0, an0}, {3'b0, e_an});
        chk({tag, ".seg0"}, seg0, e_seg);
        chk({tag, ".dp0"},  {6'b0, dp0}, {6'b0, e_dp});
      end else begin
        chk({tag, ".an1"},  {3'b0, an1}, {3'b0, e_an});
        chk({tag, ".seg1"}, seg1, e_seg);
        chk({tag, ".dp1"},  {6'b0, dp1}, {6'b0, e_dp});
      end
    end
  endtask

  task automatic frame(input string tag);
    repeat (16) begin
      tick();
      check_pins(tag);
    end
  endtask

  // Capture edge, then one more edge so the pins reflect the new shadow.
  task automatic do_load(input logic [15:0] vx, input logic [3:0] vdp, input logic [3:0] ven);
    x = vx; dp_in = vdp; en = ven; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    mx = vx; mdp = vdp; men = ven;
  endtask

  initial begin
    rst_n = 1'b1; load = 1'b0; x = '0; dp_in = '0; en = '0;
    mx = '0; mdp = '0; men = '0;
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.an0",  {3'b0, an0}, 7'h0F);
    chk("rst.seg0", seg0, 7'h7F);
    chk("rst.dp0",  {6'b0, dp0}, 7'h01);
    chk("rst.an1",  {3'b0, an1}, 7'h0F);
    chk("rst.seg1", seg1, 7'h7F);
    chk("rst.dp1",  {6'b0, dp1}, 7'h01);

    rst_n = 1'b1;
    cyc = 0;
    do_load(16'h0000, 4'b0000, 4'hF);
    frame("zero");

    do_load(16'h3A7F, 4'b0100, 4'hF);
    frame("3a7f");
    frame("3a7f2");

    for (int v = 0; v < 16; v++) begin
      do_load(16'(v), 4'b0000, 4'h1);
      frame("sweep");
    end
    // Spot check the decode table directly on a known value.
    do_load(16'h000B, 4'b0001, 4'h1);
    while (((cyc - 1) % 16) != 1) tick();
    chk("b.seg0", seg0, 7'b0000011);
    chk("b.dp0",  {6'b0, dp0}, 7'h00);
    chk("b.an0",  {3'b0, an0}, 7'h0E);

    do_load(16'h1234, 4'b0000, 4'b1010);
    frame("en1010");

    x = 16'hFFFF; dp_in = 4'hF; en = 4'hF;
    frame("noload");

    do_load(16'h0050, 4'b0000, 4'hF);
    frame("lzb");

    do_load(16'h3A7F, 4'b0000, 4'hF);
    while (((cyc - 1) % 4) != 1) tick();
    check_pins("premid");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.an0",  {3'b0, an0}, 7'h0F);
    chk("midrst.seg0", seg0, 7'h7F);
    chk("midrst.dp0",  {6'b0, dp0}, 7'h01);
    chk("midrst.an1",  {3'b0, an1}, 7'h0F);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    mx = '0; mdp = '0; men = '0;
    do_load(16'hC0DE, 4'b1001, 4'hF);
    frame("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
